// File: rtl/fft_frame_source.sv
// fft_frame_source: AXI-Stream source feeding the FFT/magnitude chain.
// Each frame starts with one config word (CFG_WORD) on m_axis_config, then
// streams FRAME_LEN complex beats {Im=0, Re=sample} with tlast on the final beat.
// Build option: define ZERO_PAD_EN so that only the first FRAME_LEN/2 beats come
// from s_axis_smp and the remaining beats are generated internally as zero.
module fft_frame_source #(
  parameter int unsigned FRAME_LEN = 128,
  parameter logic [15:0] CFG_WORD  = 16'h0003,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      s_axis_smp_tdata,
  input  logic             s_axis_smp_tvalid,
  output logic             s_axis_smp_tready,
  output logic [15:0]      m_axis_config_tdata,
  output logic             m_axis_config_tvalid,
  input  logic             m_axis_config_tready,
  output logic [63:0]      m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic             m_axis_data_tlast,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  // load_cnt must be able to hold FRAME_LEN itself ("frame fully loaded").
  localparam int unsigned LdW = $clog2(FRAME_LEN) + 1;
`ifdef ZERO_PAD_EN
  localparam int unsigned SrcLen = FRAME_LEN / 2;
`else
  localparam int unsigned SrcLen = FRAME_LEN;
`endif
  localparam logic [LdW-1:0] FrameLenC = LdW'(FRAME_LEN);
  localparam logic [LdW-1:0] LastIdx   = LdW'(FRAME_LEN - 1);
  localparam logic [LdW-1:0] SrcLenC   = LdW'(SrcLen);

  typedef enum logic [0:0] {StCfg, StData} state_e;

  state_e           state_q;
  logic [LdW-1:0]   load_cnt_q;
  logic [15:0]      cfg_data_q;
  logic             cfg_valid_q;
  logic [63:0]      data_q;
  logic             data_valid_q;
  logic             data_last_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_count_q;

  logic in_data;
  logic out_free;
  logic smp_load;
  logic pad_load;
  logic any_load;
  logic beat_hs;
  logic last_hs;

  assign in_data  = (state_q == StData);
  // Output register can take a new beat if empty or draining this cycle.
  assign out_free = ~data_valid_q | m_axis_data_tready;

  assign s_axis_smp_tready = in_data & out_free & (load_cnt_q < SrcLenC);
  assign smp_load          = s_axis_smp_tready & s_axis_smp_tvalid;

`ifdef ZERO_PAD_EN
  // Tail of the frame is filled with zero beats, no input consumed.
  assign pad_load = in_data & out_free & (load_cnt_q >= SrcLenC) & (load_cnt_q < FrameLenC);
`else
  assign pad_load = 1'b0;
`endif

  assign any_load = smp_load | pad_load;
  assign beat_hs  = data_valid_q & m_axis_data_tready;
  assign last_hs  = beat_hs & data_last_q;

  // Frame sequencer: config handshake, then load/drain of the output register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= StCfg;
      load_cnt_q    <= '0;
      cfg_data_q    <= '0;
      cfg_valid_q   <= 1'b0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StCfg: begin
          if (!cfg_valid_q) begin
            cfg_valid_q <= 1'b1;
            cfg_data_q  <= CFG_WORD;
          end else if (m_axis_config_tready) begin
            cfg_valid_q <= 1'b0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (any_load) begin
            data_q       <= smp_load ? {32'h0, s_axis_smp_tdata} : 64'h0;
            data_valid_q <= 1'b1;
            data_last_q  <= (load_cnt_q == LastIdx);
            load_cnt_q   <= load_cnt_q + 1'b1;
          end else if (beat_hs) begin
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
          end
          // All beats are loaded by the time tlast drains, so no load races this.
          if (last_hs) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
            load_cnt_q    <= '0;
            state_q       <= StCfg;
            cfg_valid_q   <= 1'b1;
            cfg_data_q    <= CFG_WORD;
          end
        end
        default: state_q <= StCfg;
      endcase
    end
  end

  assign m_axis_config_tdata  = cfg_data_q;
  assign m_axis_config_tvalid = cfg_valid_q;
  assign m_axis_data_tdata    = data_q;
  assign m_axis_data_tvalid   = data_valid_q;
  assign m_axis_data_tlast    = data_last_q;
  assign frame_done           = frame_done_q;
  assign frame_count          = frame_count_q;

endmodule

// File: tb/tb_fft_frame_source.sv
// tb_fft_frame_source: directed sequence with randomized data and handshakes,
// checked against a frame-level scoreboard of accepted samples.
module tb_fft_frame_source;

  localparam int unsigned FrameLen = 128;
`ifdef ZERO_PAD_EN
  localparam int unsigned SrcLen = FrameLen / 2;
`else
  localparam int unsigned SrcLen = FrameLen;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_smp_tdata;
  logic        s_axis_smp_tvalid;
  logic        s_axis_smp_tready;
  logic [15:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready;
  logic [63:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic        m_axis_data_tlast;
  logic        frame_done;
  logic [15:0] frame_count;

  fft_frame_source #(
    .FRAME_LEN(FrameLen),
    .CFG_WORD (16'h0003),
    .CNT_W    (16)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_smp_tdata    (s_axis_smp_tdata),
    .s_axis_smp_tvalid   (s_axis_smp_tvalid),
    .s_axis_smp_tready   (s_axis_smp_tready),
    .m_axis_config_tdata (m_axis_config_tdata),
    .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready),
    .m_axis_data_tdata   (m_axis_data_tdata),
    .m_axis_data_tvalid  (m_axis_data_tvalid),
    .m_axis_data_tready  (m_axis_data_tready),
    .m_axis_data_tlast   (m_axis_data_tlast),
    .frame_done          (frame_done),
    .frame_count         (frame_count)
  );

  always #5 aclk = ~aclk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Reference model state: frame position, accepted samples awaiting output.
  logic [31:0] smp_q[$];
  int          beat_idx   = 0;
  int          m_frames   = 0;
  bit          cfg_done   = 1'b0;
  bit          pend_done  = 1'b0;
  bit          pend_smp   = 1'b0;
  logic [31:0] pend_val   = '0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  // Monitor: outputs are stable at negedge; handshakes seen here fire on the next posedge.
  always @(negedge aclk) begin
    logic [63:0] exp_beat;
    if (areset) begin
      smp_q.delete();
      beat_idx   = 0;
      m_frames   = 0;
      cfg_done   = 1'b0;
      pend_done  = 1'b0;
      pend_smp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", frame_done, pend_done);
      check("frame_count", frame_count, 16'(m_frames));
      if (pend_smp) begin
        check("latency_valid", m_axis_data_tvalid, 1);
        check("latency_data", m_axis_data_tdata, {32'h0, pend_val});
      end
      if (prev_stall) begin
        check("hold_valid", m_axis_data_tvalid, 1);
        check("hold_data", m_axis_data_tdata, prev_data);
        check("hold_last", m_axis_data_tlast, prev_last);
      end
      if (!cfg_done) check("smp_ready_before_cfg", s_axis_smp_tready, 0);
      if (m_axis_data_tvalid && !m_axis_data_tready)
        check("smp_ready_while_stalled", s_axis_smp_tready, 0);
      check("cfg_data_overlap", m_axis_config_tvalid & m_axis_data_tvalid, 0);

      pend_done = 1'b0;
      if (m_axis_config_tvalid && m_axis_config_tready) begin
        check("cfg_word", m_axis_config_tdata, 16'h0003);
        check("cfg_once_per_frame", cfg_done, 0);
        cfg_done = 1'b1;
      end
      if (m_axis_data_tvalid && m_axis_data_tready) begin
        check("beat_after_cfg", cfg_done, 1);
        if (beat_idx < SrcLen) begin
          if (smp_q.size() == 0) begin
            exp_beat = 64'hDEAD_DEAD_DEAD_DEAD;
          end else begin
            exp_beat = {32'h0, smp_q.pop_front()};
          end
        end else begin
          exp_beat = 64'h0;
        end
        check("beat_data", m_axis_data_tdata, exp_beat);
        check("beat_last", m_axis_data_tlast, (beat_idx == FrameLen - 1) ? 1 : 0);
        if (beat_idx == FrameLen - 1) begin
          beat_idx  = 0;
          m_frames  = m_frames + 1;
          pend_done = 1'b1;
          cfg_done  = 1'b0;
        end else begin
          beat_idx = beat_idx + 1;
        end
      end
      pend_smp = s_axis_smp_tvalid & s_axis_smp_tready;
      pend_val = s_axis_smp_tdata;
      if (pend_smp) smp_q.push_back(s_axis_smp_tdata);
      prev_stall = m_axis_data_tvalid & ~m_axis_data_tready;
      prev_data  = m_axis_data_tdata;
      prev_last  = m_axis_data_tlast;
    end
  end

  // Stimulus knobs.
  int cyc        = 0;
  bit const_data = 1'b1;
  bit sv_rand    = 1'b0;
  int dr_mode    = 0;  // 0: always ready, 1: toggle 1-0-1, 2: random
  int cfg_stall  = 0;

  task automatic tick();
    logic hs;
    @(negedge aclk);
    hs = s_axis_smp_tvalid & s_axis_smp_tready;
    @(posedge aclk);
    #1;
    cyc++;
    if (!s_axis_smp_tvalid || hs) begin
      s_axis_smp_tvalid = sv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_smp_tdata  = const_data ? 32'h3F80_0000 : $urandom();
    end
    case (dr_mode)
      0:       m_axis_data_tready = 1'b1;
      1:       m_axis_data_tready = (cyc % 2) == 0;
      default: m_axis_data_tready = 1'($urandom_range(0, 1));
    endcase
    if (cfg_stall > 0 && m_axis_config_tvalid) begin
      m_axis_config_tready = 1'b0;
      cfg_stall--;
    end else begin
      m_axis_config_tready = 1'b1;
    end
  endtask

  task automatic run_frames(input int target, input string tag);
    for (int i = 0; i < 4000 && m_frames < target; i++) tick();
    check(tag, frame_count, 16'(target));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cfg_valid"}, m_axis_config_tvalid, 0);
    check({tag, "_cfg_data"}, m_axis_config_tdata, 0);
    check({tag, "_data_valid"}, m_axis_data_tvalid, 0);
    check({tag, "_data"}, m_axis_data_tdata, 0);
    check({tag, "_tlast"}, m_axis_data_tlast, 0);
    check({tag, "_smp_ready"}, s_axis_smp_tready, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  initial begin
    areset               = 1'b1;
    s_axis_smp_tdata     = '0;
    s_axis_smp_tvalid    = 1'b0;
    m_axis_config_tready = 1'b0;
    m_axis_data_tready   = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_idle("reset");

    // Release; config must appear on the first edge and be taken on the second.
    areset               = 1'b0;
    m_axis_config_tready = 1'b1;
    m_axis_data_tready   = 1'b1;
    s_axis_smp_tvalid    = 1'b1;
    s_axis_smp_tdata     = 32'h3F80_0000;
    @(posedge aclk);
    #1;
    check("first_cfg_valid", m_axis_config_tvalid, 1);
    check("first_cfg_word", m_axis_config_tdata, 16'h0003);
    check("first_no_data", m_axis_data_tvalid, 0);
    @(posedge aclk);
    #1;
    check("cfg_taken", m_axis_config_tvalid, 0);
    check("smp_ready_after_cfg", s_axis_smp_tready, 1);

    // Frame 1: constant 1.0f, full-rate.
    run_frames(1, "frame1_count");
    check("frame1_idle_data", m_axis_data_tvalid, 0);
    check("frame1_next_cfg", m_axis_config_tvalid, 1);

    // Frame 2: random data, output ready toggling 1-0-1.
    const_data = 1'b0;
    dr_mode    = 1;
    run_frames(2, "frame2_count");

    // Frames 3 and 4: config held off 5 cycles, random input and output handshakes.
    dr_mode              = 2;
    sv_rand              = 1'b1;
    m_axis_config_tready = 1'b0;
    cfg_stall            = 4;
    check("gap_cfg_pending", m_axis_config_tvalid, 1);
    run_frames(3, "frame3_count");
    m_axis_config_tready = 1'b0;
    cfg_stall            = 4;
    run_frames(4, "frame4_count");

    // Mid-frame reset at beat 40.
    dr_mode = 0;
    sv_rand = 1'b0;
    for (int i = 0; i < 4000 && beat_idx < 40; i++) tick();
    check("reached_beat40_count", frame_count, 16'd4);
    #2;
    areset = 1'b1;
    #1;
    check_idle("midreset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("post_reset_cfg_valid", m_axis_config_tvalid, 1);
    check("post_reset_count", frame_count, 0);
    check("post_reset_no_data", m_axis_data_tvalid, 0);
    run_frames(1, "post_reset_frame_count");

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_source.md
Name: fft_frame_source

Overview:
- AXI-Stream transmitter that feeds the FFT/magnitude chain.
- Sends one FFT config word per frame, then streams FRAME_LEN complex beats {Im=0, Re=sample} with tlast on the final beat.
- Takes real 32-bit float audio samples on a slave stream.
- Replaces the hand-driven config/data stimulus currently used in front of the FFT core.

Parameters:
- FRAME_LEN, 128: beats per FFT frame; power of two, 8..1024.
- CFG_WORD, 16'h0003: value presented on m_axis_config_tdata each frame.
- CNT_W, 16: width of frame_count.

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  asynchronous reset, active-high.
- s_axis_smp_tdata  in  32  real sample (IEEE-754 single).
- s_axis_smp_tvalid  in  1  sample valid.
- s_axis_smp_tready  out  1  sample accepted when tvalid&tready.
- m_axis_config_tdata  out  16  FFT config word.
- m_axis_config_tvalid  out  1  config valid.
- m_axis_config_tready  in  1  FFT accepts config.
- m_axis_data_tdata  out  64  [63:32]=Im (always 0), [31:0]=Re.
- m_axis_data_tvalid  out  1  data valid.
- m_axis_data_tready  in  1  FFT accepts data.
- m_axis_data_tlast  out  1  high on beat FRAME_LEN-1 of each frame.
- frame_done  out  1  one-cycle pulse when the tlast beat handshakes.
- frame_count  out  CNT_W  completed frames; wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=S_CFG, m_axis_config_tvalid=0, m_axis_data_tvalid=0, tlast=0, tdata=0, s_axis_smp_tready=0, frame_done=0, frame_count=0, load_cnt=0.
- First cycle after release: m_axis_config_tvalid=1, m_axis_config_tdata=CFG_WORD.
- S_CFG:
  - config_tvalid held high, tdata stable until config_tready=1.
  - On handshake: config_tvalid=0 next cycle, go to S_DATA.
  - s_axis_smp_tready=0 throughout.
- S_DATA: single output register stage.
  - s_axis_smp_tready = (load_cnt<FRAME_LEN) & (!m_axis_data_tvalid | m_axis_data_tready).
  - On sample handshake, next cycle: m_axis_data_tdata={32'h0, sample}, tvalid=1, tlast=(load_cnt==FRAME_LEN-1), load_cnt++.
  - Latency: sample to output is 1 cycle.
  - Throughput: 1 beat/cycle while both sides are ready.
  - Output hold: while tvalid & !tready, tdata/tlast held stable and no new sample accepted.
  - Drain: output register clears (tvalid=0) when its beat handshakes and no new load occurs the same cycle.
  - Simultaneous drain+load in one cycle is legal: register replaced, tvalid stays 1.
- Frame end: on the tlast beat handshake:
  - frame_done=1 for one cycle, frame_count++ (wrap), load_cnt=0.
  - state=S_CFG; next config presented the following cycle.
- No data beat ever overlaps a pending config. The next frame's first sample is never accepted before config completes.
- areset mid-frame: partial frame discarded, outputs to reset values, next frame restarts with config.

Optional Feature:
- Macro ZERO_PAD_EN.
- Defined:
  - Only the first FRAME_LEN/2 beats come from s_axis_smp.
  - Beats FRAME_LEN/2..FRAME_LEN-1 are generated internally as 64'h0; s_axis_smp_tready=0 during them.
  - Same output handshake and tlast rules apply.
- Undefined: all FRAME_LEN beats come from the input stream.

Test Plan:
- Reset then config_tready=1 -> exactly one config beat of 16'h0003, accepted 1 cycle after release; no data tvalid before it.
- 128 samples of 32'h3F800000, tready=1 -> 128 beats of 64'h000000003F800000, tlast only on beat 127, frame_done pulse, frame_count=1.
- m_axis_data_tready toggled 1-0-1 with a continuous input -> no lost or duplicated beat; data stable while stalled; beat order 0..127 preserved.
- Two back-to-back frames, config_tready held 0 for 5 cycles between them -> input stalled for those cycles; frame_count=2; second frame begins only after the config handshake.
- areset pulsed at beat 40 -> all outputs zero immediately; after release a fresh config beat appears; frame_count=0.
- ZERO_PAD_EN, 64 samples of 32'h3F800000 -> 64 one-beats, then 64 zero beats with s_axis_smp_tready=0, tlast on beat 127.
